instr_queue: RTL and testbench
==============================

# instr_queue

Circular FIFO between the instruction fetcher and the decoder. Buffers fetched (pc, instr) pairs and presents the oldest entry to the decoder, together with an empty flag. Supports a single-cycle flush on branch mispredict/redirect and a stall enable from the global ready line. Occupancy flags throttle the fetcher.

## Interface
- `DEPTH_LOG2`, default 4: log2 of entry count; DEPTH = 2^DEPTH_LOG2 = 16.
- `PC_W`, default 32: pc width.
- `INSTR_W`, default 32: instruction width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable. When low, all state holds.
- `flush` in 1: discard all entries (redirect).
- `push_valid` in 1: fetcher presents a new entry.
- `push_pc` in PC_W: pc of the pushed instruction.
- `push_instr` in INSTR_W: pushed instruction word.
- `full` out 1: count == DEPTH.
- `almost_full` out 1: count >= DEPTH-2; the fetcher stops issuing new fetches.
- `pop` in 1: decoder consumes the head entry this cycle.
- `is_empty_to_decoder` out 1: count == 0.
- `pc_to_decoder` out PC_W: pc of the head entry.
- `instr_to_decoder` out INSTR_W: instruction word of the head entry.
- `count` out DEPTH_LOG2+1: current occupancy.

## Operation
- State: storage array of DEPTH entries (pc and instr), head pointer, tail pointer (DEPTH_LOG2 bits each, natural wrap), and `count`.
- Reset (async): head=0, tail=0, count=0. Array contents are don't-care and are not cleared.
- Per rising edge with `rdy`=1, in priority order:
  - `flush`=1: head=0, tail=0, count=0. Same-cycle push and pop are ignored.
  - Otherwise, the push is effective when `push_valid` && !full. It writes to mem[tail] and increments tail.
  - The pop is effective when `pop` && !is_empty. It increments head.
  - Push and pop effective together: count unchanged. Push only: count+1. Pop only: count-1.
  - Full with push_valid and pop both high: the pop is effective, and the push is dropped, because `full` is evaluated before the pop. The fetcher must honour `almost_full`.
  - Pop while empty: ignored, no underflow.
- With `rdy`=0, nothing changes, including flush.
- Head output: when count>0, the pc/instr outputs drive mem[head] combinationally. When empty they drive 0.
- Pointers wrap from DEPTH-1 to 0 with no special case.

## Timing
- Reset values: is_empty_to_decoder=1, full=0, almost_full=0, count=0, pc_to_decoder=0, instr_to_decoder=0.
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on the outputs after edge N when it is the head.
- Pop at edge N: the next entry, or empty, is shown after edge N.
- Flush at edge N: is_empty_to_decoder=1 immediately after edge N. A push at edge N+1 is accepted normally.
- Flags (`full`, `almost_full`, `is_empty_to_decoder`, `count`) derive combinationally from the registered count, so they change only after clock edges or reset.
- An async `rst` mid-operation drops all entries immediately.

## Configuration
- `IQ_BYPASS_EN`
  - Defined: when the queue is empty (count==0) and push_valid=1, the outputs drive push_pc/push_instr combinationally and is_empty_to_decoder=0 in the same cycle.
    - If `pop`=1 in that same cycle, the entry is consumed directly: no write, and pointers and count are unchanged.
    - If `pop`=0, the entry is written normally.
  - Undefined: there is no bypass, and the minimum push-to-decode latency is 1 cycle as specified above.

## Test plan
- Reset then idle: rst pulse with no push -> is_empty=1, pc/instr=0, count=0, full=0.
- Fill and drain: push 16 entries with pc=0x0..0x3C and instr=0x13+i, no pop -> full=1, almost_full set at count 14. Pop 16 -> pc sequence 0x0,0x4,…,0x3C in order, then is_empty=1.
- Wrap-around: push 10, pop 10, push 10 (pc=0x100+4i), pop 10 -> order preserved across the pointer wrap, count returns to 0.
- Simultaneous push/pop at count 5 -> count stays 5 and the head advances. Full with push+pop -> count 15, and the pushed entry is dropped.
- Flush with push_valid=1 and pop=1 at count 7 -> count=0 and is_empty=1 next cycle. A push of pc=0x200 on the following cycle then appears at the head.
- rdy=0 with push_valid=1, pop=1 and flush=1 for 3 cycles -> no state change. Separately, with IQ_BYPASS_EN on an empty queue, push pc=0x40 with pop=1 -> pc_to_decoder=0x40 in the same cycle and count stays 0.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of (pc, instr) pairs between the fetcher and the decoder.
// The head entry is presented combinationally. The queue flushes in a single cycle and
// holds all of its state while rdy is low. The occupancy flags throttle the fetcher.
// Optional feature: define IQ_BYPASS_EN to present a push straight to the decoder
// when the queue is empty. If pop is high in that same cycle, the entry is consumed
// without being written.
module instr_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [PC_W-1:0]       push_pc,
  input  logic [INSTR_W-1:0]    push_instr,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  pop,
  output logic                  is_empty_to_decoder,
  output logic [PC_W-1:0]       pc_to_decoder,
  output logic [INSTR_W-1:0]    instr_to_decoder,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_AF   = (DEPTH_LOG2+1)'(DEPTH - 2);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Storage is deliberately left out of reset; only pointers and occupancy are control.
  logic [PC_W-1:0]       mem_pc    [DEPTH];
  logic [INSTR_W-1:0]    mem_instr [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count_r;

  logic empty_w;
  logic bypass_show;
  logic bypass_consume;
  logic push_eff;
  logic pop_eff;

  // Pointers wrap naturally at DEPTH because of their width.
  function automatic logic [DEPTH_LOG2-1:0] ptr_inc(input logic [DEPTH_LOG2-1:0] p);
    return p + PTR_ONE;
  endfunction

  // Flags come from the registered count only, so they move only on clock edges or reset.
  always_comb begin
    full        = (count_r == CNT_FULL);
    almost_full = (count_r >= CNT_AF);
    empty_w     = (count_r == '0);
    count       = count_r;
  end

  // Bypass qualification: an empty queue with a push in flight.
  always_comb begin
`ifdef IQ_BYPASS_EN
    bypass_show    = empty_w && push_valid;
    bypass_consume = empty_w && push_valid && pop;
`else
    bypass_show    = 1'b0;
    bypass_consume = 1'b0;
`endif
  end

  // Effective push/pop. Full is judged before any same-cycle pop, so a push into a full queue is dropped.
  always_comb begin
    push_eff = push_valid && !full && !bypass_consume;
    pop_eff  = pop && !empty_w;
  end

  // Head presentation: bypass data, stored head entry, or zero when empty.
  always_comb begin
    is_empty_to_decoder = empty_w;
    pc_to_decoder       = '0;
    instr_to_decoder    = '0;
    if (bypass_show) begin
      is_empty_to_decoder = 1'b0;
      pc_to_decoder       = push_pc;
      instr_to_decoder    = push_instr;
    end else if (!empty_w) begin
      pc_to_decoder       = mem_pc[head];
      instr_to_decoder    = mem_instr[head];
    end
  end

  // Entry write at the tail on an effective push.
  always_ff @(posedge clk) begin
    if (rdy && !flush && push_eff) begin
      mem_pc[tail]    <= push_pc;
      mem_instr[tail] <= push_instr;
    end
  end

  // Pointer and occupancy update. Flush wins over push and pop, and rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else if (rdy) begin
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count_r <= '0;
      end else begin
        if (push_eff) tail <= ptr_inc(tail);
        if (pop_eff)  head <= ptr_inc(head);
        case ({push_eff, pop_eff})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue. A queue-based reference model tracks the expected contents.
// A negedge compare process checks every output against that model on every cycle.
// Directed sequences pin the model with literal values, and a randomized phase follows.
module tb_instr_queue;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic        pop = 1'b0;
  logic        full;
  logic        almost_full;
  logic        is_empty_to_decoder;
  logic [31:0] pc_to_decoder;
  logic [31:0] instr_to_decoder;
  logic [DEPTH_LOG2:0] count;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit started   = 1'b0;

  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];

  instr_queue #(.DEPTH_LOG2(DEPTH_LOG2), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .full(full), .almost_full(almost_full), .pop(pop),
    .is_empty_to_decoder(is_empty_to_decoder), .pc_to_decoder(pc_to_decoder),
    .instr_to_decoder(instr_to_decoder), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of entries, updated from the rules at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_pc.delete();
      q_ins.delete();
    end else if (rdy) begin
      if (flush) begin
        q_pc.delete();
        q_ins.delete();
      end else begin
        bit was_full, was_empty, byp, do_push, do_pop;
        was_full  = (q_pc.size() == DEPTH);
        was_empty = (q_pc.size() == 0);
        byp = 1'b0;
`ifdef IQ_BYPASS_EN
        byp = was_empty && push_valid && pop;
`endif
        do_pop  = pop && !was_empty;
        do_push = push_valid && !was_full && !byp;
        if (do_pop) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
        if (do_push) begin
          q_pc.push_back(push_pc);
          q_ins.push_back(push_instr);
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (started) begin
      int n;
      logic [31:0] epc, eins;
      logic eempty;
      n = q_pc.size();
      eempty = (n == 0);
      epc  = (n > 0) ? q_pc[0]  : 32'h0;
      eins = (n > 0) ? q_ins[0] : 32'h0;
`ifdef IQ_BYPASS_EN
      if (n == 0 && push_valid) begin
        eempty = 1'b0;
        epc  = push_pc;
        eins = push_instr;
      end
`endif
      chk("count", 64'(count), 64'(n));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(n >= DEPTH - 2));
      chk("empty", 64'(is_empty_to_decoder), 64'(eempty));
      chk("pc", 64'(pc_to_decoder), 64'(epc));
      chk("instr", 64'(instr_to_decoder), 64'(eins));
    end
  end

  // One clock of stimulus. It is entered and left just after a falling edge.
  task automatic cyc(input logic pv, input logic [31:0] p, input logic [31:0] ins,
                     input logic po, input logic fl, input logic r);
    push_valid = pv; push_pc = p; push_instr = ins; pop = po; flush = fl; rdy = r;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    started = 1'b1;
    idle();

    // Reset then idle.
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(is_empty_to_decoder), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_pc", 64'(pc_to_decoder), 64'd0);
    chk("rst_instr", 64'(instr_to_decoder), 64'd0);

    // Fill to full, with almost_full rising at 14.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(4*i), 32'(32'h13 + i), 1'b0, 1'b0, 1'b1);
      chk("fill_af", 64'(almost_full), 64'((i + 1) >= 14));
    end
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_full", 64'(full), 64'd1);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      chk("drain_pc", 64'(pc_to_decoder), 64'(4*i));
      chk("drain_instr", 64'(instr_to_decoder), 64'(32'h13 + i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    end
    chk("drain_empty", 64'(is_empty_to_decoder), 64'd1);

    // Wrap-around of both pointers.
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'(32'h80 + 4*i), 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'(32'h100 + 4*i), 32'(32'hA0 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_pc", 64'(pc_to_decoder), 64'(32'h100 + 4*i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    end
    chk("wrap_count", 64'(count), 64'd0);

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(32'h300 + 4*i), 32'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h400, 32'h55, 1'b1, 1'b0, 1'b1);
    chk("pp5_count", 64'(count), 64'd5);
    chk("pp5_head", 64'(pc_to_decoder), 64'h304);

    // Full with push and pop: the pop happens, the push is dropped.
    for (int i = 0; i < 11; i++) cyc(1'b1, 32'(32'h500 + 4*i), 32'(i), 1'b0, 1'b0, 1'b1);
    chk("pre_full", 64'(full), 64'd1);
    cyc(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    chk("fullpp_count", 64'(count), 64'd15);
    for (int i = 0; i < 15; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Flush at count 7, with push and pop also asserted.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'(32'h600 + 4*i), 32'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h700, 32'h1, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(is_empty_to_decoder), 64'd1);
    cyc(1'b1, 32'h200, 32'h77, 1'b0, 1'b0, 1'b1);
    chk("postflush_pc", 64'(pc_to_decoder), 64'h200);

    // rdy low freezes everything, including flush.
    cyc(1'b1, 32'h204, 32'h78, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h999, 32'h9, 1'b1, 1'b1, 1'b0);
    chk("stall_count", 64'(count), 64'd2);
    chk("stall_pc", 64'(pc_to_decoder), 64'h200);
    for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

`ifdef IQ_BYPASS_EN
    // Bypass on an empty queue, consumed in the same cycle.
    push_valid = 1'b1; push_pc = 32'h40; push_instr = 32'h33; pop = 1'b1; flush = 1'b0; rdy = 1'b1;
    #1;
    chk("byp_pc", 64'(pc_to_decoder), 64'h40);
    chk("byp_empty", 64'(is_empty_to_decoder), 64'd0);
    @(negedge clk); #1;
    push_valid = 1'b0; pop = 1'b0;
    #1;
    chk("byp_count", 64'(count), 64'd0);
    @(negedge clk); #1;
`endif

    // Asynchronous reset in the middle of operation.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(32'h800 + 4*i), 32'(i), 1'b0, 1'b0, 1'b1);
    push_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(is_empty_to_decoder), 64'd1);
    @(negedge clk); #1;
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 9) < 6), $urandom, $urandom,
          1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 99) < 3),
          1'($urandom_range(0, 99) < 85));
    end

    started = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
